// File: rtl/icache_burst.sv
// icache_burst: set-associative instruction cache, zero-wait hits, line refill over an AXI-style read burst.
// Build option ICACHE_FLUSH_EN adds the FLUSH port and the INVAL state (invalidate-all, one set per cycle).
module icache_burst #(
  parameter int WAYS       = 2,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  CPU_REQ,
  input  logic [ADDR_WIDTH-1:0] CPU_REQ_ADDR,
  output logic                  CPU_REQ_VALID,
  output logic [31:0]           CPU_REQ_DATA,
  output logic                  BUSY,
  output logic                  AR_VALID,
  input  logic                  AR_READY,
  output logic [ADDR_WIDTH-1:0] AR_ADDR,
  output logic [7:0]            AR_LEN,
  input  logic                  R_VALID,
  output logic                  R_READY,
  input  logic [31:0]           R_DATA,
  input  logic                  R_LAST
`ifdef ICACHE_FLUSH_EN
  ,
  input  logic                  FLUSH
`endif
);

  localparam int WORD_W     = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(SETS);
  localparam int TAG_W      = ADDR_WIDTH - IDX_W - WORD_W - 2;
  localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int LINE_DEPTH = SETS * LINE_WORDS;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMP,
    S_MREQ,
    S_REFILL,
    S_READ
`ifdef ICACHE_FLUSH_EN
    ,
    S_INVAL
`endif
  } state_t;

  state_t state_reg, state_next;

  logic [TAG_W-1:0]      req_tag;
  logic [IDX_W-1:0]      req_idx;
  logic [WORD_W-1:0]     req_word;

  logic [TAG_W-1:0]      tag_lat_reg;
  logic [IDX_W-1:0]      idx_lat_reg;
  logic [WORD_W-1:0]     word_lat_reg;
  logic [WAY_W-1:0]      victim_reg;
  logic [ADDR_WIDTH-1:0] ar_addr_reg;
  logic [WORD_W-1:0]     cnt_reg;
  logic [31:0]           rd_word_reg;
  logic [WAYS-1:0]       valid_reg [SETS];

  logic                  miss_take;
  logic                  beat_wr;
  logic                  line_commit;
  logic                  line_abort;
  logic                  hit_any;
  logic [31:0]           hit_data;
  logic [WAY_W-1:0]      victim_sel;
  logic [WAY_W-1:0]      rr_cur;

  logic [TAG_W-1:0]      tag_rd  [WAYS];
  logic [31:0]           data_rd [WAYS];
  logic [WAYS-1:0]       hit_vec;

  // Byte-offset bits carry no information for word-aligned fetches.
  logic                  unused_addr_bits;
  assign unused_addr_bits = ^CPU_REQ_ADDR[1:0];

  assign req_tag  = CPU_REQ_ADDR[ADDR_WIDTH-1 -: TAG_W];
  assign req_idx  = CPU_REQ_ADDR[2+WORD_W +: IDX_W];
  assign req_word = CPU_REQ_ADDR[2 +: WORD_W];

  assign AR_ADDR = ar_addr_reg;
  assign AR_LEN  = 8'(LINE_WORDS - 1);
  assign BUSY    = ~CPU_REQ_VALID;

`ifdef ICACHE_FLUSH_EN
  logic             flush_pend_reg;
  logic [IDX_W-1:0] inv_cnt_reg;
  logic             flush_req;
  assign flush_req = FLUSH | flush_pend_reg;

  // A flush seen while a burst is in flight is held until the fetch completes.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      flush_pend_reg <= 1'b0;
      inv_cnt_reg    <= '0;
    end else begin
      if (state_reg == S_INVAL)
        inv_cnt_reg <= inv_cnt_reg + 1'b1;
      if (state_next == S_INVAL)
        flush_pend_reg <= 1'b0;
      else if (FLUSH && (state_reg == S_MREQ || state_reg == S_REFILL))
        flush_pend_reg <= 1'b1;
    end
  end
`endif

  // Per-way tag and data storage; reads are asynchronous so a hit returns in the lookup cycle.
  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_way
      logic [TAG_W-1:0] tag_mem  [SETS];
      logic [31:0]      data_mem [LINE_DEPTH];

      always_ff @(posedge ACLK) begin
        if (beat_wr && !ARESET && victim_reg == WAY_W'(gi))
          data_mem[{idx_lat_reg, cnt_reg}] <= R_DATA;
        if (line_commit && !ARESET && victim_reg == WAY_W'(gi))
          tag_mem[idx_lat_reg] <= tag_lat_reg;
      end

      assign tag_rd[gi]  = tag_mem[req_idx];
      assign data_rd[gi] = data_mem[{req_idx, req_word}];
      assign hit_vec[gi] = valid_reg[req_idx][gi] && (tag_rd[gi] == req_tag);
    end

    if (WAYS > 1) begin : g_rr
      logic [WAY_W-1:0] rr_reg [SETS];
      always_ff @(posedge ACLK) begin
        if (ARESET) begin
          for (int s = 0; s < SETS; s++)
            rr_reg[s] <= '0;
        end else if (line_commit) begin
          rr_reg[idx_lat_reg] <= rr_reg[idx_lat_reg] + 1'b1;
        end
      end
      assign rr_cur = rr_reg[req_idx];
    end else begin : g_no_rr
      assign rr_cur = '0;
    end
  endgenerate

  // Descending scans leave the lowest matching way selected.
  always_comb begin
    hit_any    = |hit_vec;
    hit_data   = NOP;
    victim_sel = rr_cur;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w])
        hit_data = data_rd[w];
      if (!valid_reg[req_idx][w])
        victim_sel = WAY_W'(w);
    end
  end

  always_comb begin
    state_next    = state_reg;
    miss_take     = 1'b0;
    beat_wr       = 1'b0;
    line_commit   = 1'b0;
    line_abort    = 1'b0;
    CPU_REQ_VALID = 1'b0;
    CPU_REQ_DATA  = NOP;
    AR_VALID      = 1'b0;
    R_READY       = 1'b0;
    case (state_reg)
      S_IDLE: begin
`ifdef ICACHE_FLUSH_EN
        if (flush_req)
          state_next = S_INVAL;
        else
`endif
        if (CPU_REQ)
          state_next = S_CMP;
      end
      S_CMP: begin
`ifdef ICACHE_FLUSH_EN
        if (flush_req)
          state_next = S_INVAL;
        else
`endif
        if (!CPU_REQ) begin
          state_next = S_IDLE;
        end else if (hit_any) begin
          CPU_REQ_VALID = 1'b1;
          CPU_REQ_DATA  = hit_data;
        end else begin
          miss_take  = 1'b1;
          state_next = S_MREQ;
        end
      end
      S_MREQ: begin
        AR_VALID = 1'b1;
        if (AR_READY)
          state_next = S_REFILL;
      end
      S_REFILL: begin
        R_READY = 1'b1;
        if (R_VALID) begin
          beat_wr = 1'b1;
          // A full line commits even without R_LAST; an early R_LAST abandons it.
          if (cnt_reg == WORD_W'(LINE_WORDS - 1)) begin
            line_commit = 1'b1;
            state_next  = S_READ;
          end else if (R_LAST) begin
            line_abort = 1'b1;
            state_next = S_CMP;
          end
        end
      end
      S_READ: begin
        CPU_REQ_VALID = 1'b1;
        CPU_REQ_DATA  = rd_word_reg;
`ifdef ICACHE_FLUSH_EN
        if (flush_req)
          state_next = S_INVAL;
        else
`endif
        if (CPU_REQ)
          state_next = S_CMP;
        else
          state_next = S_IDLE;
      end
`ifdef ICACHE_FLUSH_EN
      S_INVAL: begin
        if (inv_cnt_reg == IDX_W'(SETS - 1))
          state_next = S_IDLE;
      end
`endif
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_reg   <= S_IDLE;
      ar_addr_reg <= '0;
      cnt_reg     <= '0;
      for (int s = 0; s < SETS; s++)
        valid_reg[s] <= '0;
    end else begin
      state_reg <= state_next;
      if (miss_take) begin
        tag_lat_reg  <= req_tag;
        idx_lat_reg  <= req_idx;
        word_lat_reg <= req_word;
        victim_reg   <= victim_sel;
        ar_addr_reg  <= {CPU_REQ_ADDR[ADDR_WIDTH-1:WORD_W+2], {(WORD_W+2){1'b0}}};
        // The victim goes invalid now so a partial or aborted refill can never hit.
        valid_reg[req_idx][victim_sel] <= 1'b0;
      end
      if (beat_wr) begin
        cnt_reg <= cnt_reg + 1'b1;
        if (cnt_reg == word_lat_reg)
          rd_word_reg <= R_DATA;
      end
      if (line_commit || line_abort)
        cnt_reg <= '0;
      if (line_commit)
        valid_reg[idx_lat_reg][victim_reg] <= 1'b1;
`ifdef ICACHE_FLUSH_EN
      if (state_reg == S_INVAL)
        valid_reg[inv_cnt_reg] <= '0;
`endif
    end
  end

endmodule

// File: tb/tb_icache_burst.sv
// Directed bench for icache_burst at default parameters; flush scenario runs when ICACHE_FLUSH_EN is defined.
module tb_icache_burst;

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic        CPU_REQ;
  logic [31:0] CPU_REQ_ADDR;
  logic        CPU_REQ_VALID;
  logic [31:0] CPU_REQ_DATA;
  logic        BUSY;
  logic        AR_VALID;
  logic        AR_READY;
  logic [31:0] AR_ADDR;
  logic [7:0]  AR_LEN;
  logic        R_VALID;
  logic        R_READY;
  logic [31:0] R_DATA;
  logic        R_LAST;
`ifdef ICACHE_FLUSH_EN
  logic        FLUSH;
`endif

  int errors = 0;
  int checks = 0;

  always #5 ACLK = ~ACLK;

  icache_burst dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .CPU_REQ       (CPU_REQ),
    .CPU_REQ_ADDR  (CPU_REQ_ADDR),
    .CPU_REQ_VALID (CPU_REQ_VALID),
    .CPU_REQ_DATA  (CPU_REQ_DATA),
    .BUSY          (BUSY),
    .AR_VALID      (AR_VALID),
    .AR_READY      (AR_READY),
    .AR_ADDR       (AR_ADDR),
    .AR_LEN        (AR_LEN),
    .R_VALID       (R_VALID),
    .R_READY       (R_READY),
    .R_DATA        (R_DATA),
    .R_LAST        (R_LAST)
`ifdef ICACHE_FLUSH_EN
    ,
    .FLUSH         (FLUSH)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic fetch_req(input logic [31:0] addr);
    @(negedge ACLK);
    CPU_REQ      = 1'b1;
    CPU_REQ_ADDR = addr;
  endtask

  // Fetch expected to hit: allows one cycle for IDLE->CMP, then demands same-cycle data.
  task automatic hit(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    int n;
    @(negedge ACLK);
    CPU_REQ      = 1'b1;
    CPU_REQ_ADDR = addr;
    #1;
    n = 0;
    while (CPU_REQ_VALID !== 1'b1 && n < 1) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    check({tag, "_valid"}, CPU_REQ_VALID, 32'd1);
    check({tag, "_data"}, CPU_REQ_DATA, exp);
    check({tag, "_busy"}, BUSY, 32'd0);
    $display("hit   %s addr=%h data=%h", tag, addr, CPU_REQ_DATA);
  endtask

  // Acts as the memory: waits for the miss request, then returns LINE_WORDS beats base+k.
  task automatic serve_burst(input string tag, input logic [31:0] exp_ar, input logic [31:0] base,
                             input int ar_wait, input int gap, input int abort_at, input int rst_at,
                             input bit drop, input logic [31:0] exp_word);
    int n;
    #1;
    n = 0;
    while (AR_VALID !== 1'b1 && n < 6) begin
      @(negedge ACLK);
      #1;
      n++;
    end
    check({tag, "_arvalid"}, AR_VALID, 32'd1);
    check({tag, "_araddr"}, AR_ADDR, exp_ar);
    check({tag, "_arlen"}, AR_LEN, 32'd7);
    for (int i = 0; i < ar_wait; i++) begin
      @(negedge ACLK);
      #1;
      check({tag, "_stall_arvalid"}, AR_VALID, 32'd1);
      check({tag, "_stall_araddr"}, AR_ADDR, exp_ar);
    end
    @(negedge ACLK);
    AR_READY = 1'b1;
    if (drop) begin
      CPU_REQ      = 1'b0;
      CPU_REQ_ADDR = 32'h0000_03FC;
    end
    @(negedge ACLK);
    AR_READY = 1'b0;
    #1;
    check({tag, "_ar_drop"}, AR_VALID, 32'd0);
    check({tag, "_rready"}, R_READY, 32'd1);
    for (int k = 0; k < 8; k++) begin
      for (int g = 0; g < gap; g++) begin
        R_VALID = 1'b0;
        @(negedge ACLK);
      end
      R_VALID = 1'b1;
      R_DATA  = base + 32'(k);
      R_LAST  = (k == 7) || (k == abort_at);
      ARESET  = (k == rst_at);
      @(negedge ACLK);
      R_VALID = 1'b0;
      R_LAST  = 1'b0;
      if (k == rst_at) begin
        ARESET  = 1'b0;
        CPU_REQ = 1'b0;
        #1;
        check({tag, "_rst_rready"}, R_READY, 32'd0);
        check({tag, "_rst_arvalid"}, AR_VALID, 32'd0);
        check({tag, "_rst_araddr"}, AR_ADDR, 32'd0);
        check({tag, "_rst_valid"}, CPU_REQ_VALID, 32'd0);
        $display("reset %s during beat %0d", tag, k);
        return;
      end
      if (k == abort_at) begin
        #1;
        check({tag, "_abort_rready"}, R_READY, 32'd0);
        check({tag, "_abort_valid"}, CPU_REQ_VALID, 32'd0);
        $display("abort %s at beat %0d", tag, k);
        return;
      end
    end
    #1;
    check({tag, "_read_valid"}, CPU_REQ_VALID, 32'd1);
    check({tag, "_read_data"}, CPU_REQ_DATA, exp_word);
    $display("miss  %s line=%h data=%h", tag, exp_ar, CPU_REQ_DATA);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ARESET       = 1'b1;
    CPU_REQ      = 1'b0;
    CPU_REQ_ADDR = '0;
    AR_READY     = 1'b0;
    R_VALID      = 1'b0;
    R_DATA       = '0;
    R_LAST       = 1'b0;
`ifdef ICACHE_FLUSH_EN
    FLUSH        = 1'b0;
`endif
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    check("rst_valid", CPU_REQ_VALID, 32'd0);
    check("rst_data", CPU_REQ_DATA, 32'h0000_0013);
    check("rst_busy", BUSY, 32'd1);
    check("rst_arvalid", AR_VALID, 32'd0);
    check("rst_rready", R_READY, 32'd0);
    check("rst_araddr", AR_ADDR, 32'd0);
    check("rst_arlen", AR_LEN, 32'd7);

    // Cold miss then zero-wait hits in the same line.
    fetch_req(32'h100);
    serve_burst("cold100", 32'h100, 32'hA0, 0, 0, -1, -1, 1'b0, 32'hA0);
    hit("h11c", 32'h11C, 32'hA7);
    hit("h100", 32'h100, 32'hA0);
    hit("h110", 32'h110, 32'hA4);

    @(negedge ACLK);
    CPU_REQ = 1'b0;
    #1;
    check("noreq_valid", CPU_REQ_VALID, 32'd0);
    check("noreq_data", CPU_REQ_DATA, 32'h0000_0013);
    check("noreq_busy", BUSY, 32'd1);

    // Same index 0: fill both ways, third tag evicts way 0 (AR stall and R gaps on the way).
    fetch_req(32'h0);
    serve_burst("m000", 32'h0, 32'hB0, 5, 1, -1, -1, 1'b0, 32'hB0);
    fetch_req(32'h800);
    serve_burst("m800", 32'h800, 32'hC0, 0, 2, -1, -1, 1'b0, 32'hC0);
    hit("h000", 32'h0, 32'hB0);
    hit("h804", 32'h804, 32'hC1);
    fetch_req(32'h1008);
    serve_burst("m1000", 32'h1000, 32'hD0, 0, 0, -1, -1, 1'b0, 32'hD2);
    hit("h80c", 32'h80C, 32'hC3);
    hit("h1000", 32'h1000, 32'hD0);
    fetch_req(32'h0);
    serve_burst("re000", 32'h0, 32'hB0, 0, 0, -1, -1, 1'b0, 32'hB0);

    // Request withdrawn mid-miss: the latched word is still returned.
    fetch_req(32'h204);
    serve_burst("drop204", 32'h200, 32'hE0, 0, 0, -1, -1, 1'b1, 32'hE1);
    hit("h204", 32'h204, 32'hE1);
    hit("h208", 32'h208, 32'hE2);

    // Early R_LAST on beat 4: line not kept, same burst address reissued.
    fetch_req(32'h300);
    serve_burst("abort300", 32'h300, 32'hF0, 0, 0, 4, -1, 1'b0, 32'hF0);
    serve_burst("retry300", 32'h300, 32'hF0, 0, 0, -1, -1, 1'b0, 32'hF0);
    hit("h31c", 32'h31C, 32'hF7);

    // Reset during beat 3 wipes all valid lines.
    hit("h104", 32'h104, 32'hA1);
    fetch_req(32'h2000);
    serve_burst("rst2000", 32'h2000, 32'h50, 0, 0, -1, 3, 1'b0, 32'h50);
    fetch_req(32'h104);
    serve_burst("post_rst104", 32'h100, 32'hA0, 0, 0, -1, -1, 1'b0, 32'hA1);

`ifdef ICACHE_FLUSH_EN
    hit("pre_flush104", 32'h104, 32'hA1);
    @(negedge ACLK);
    FLUSH = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge ACLK);
      FLUSH = 1'b0;
      #1;
      check("flush_busy", BUSY, 32'd1);
    end
    $display("flush 64 busy cycles observed");
    serve_burst("post_flush104", 32'h100, 32'hA0, 0, 0, -1, -1, 1'b0, 32'hA1);
`endif

    @(negedge ACLK);
    CPU_REQ = 1'b0;
    repeat (2) @(negedge ACLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_burst.md
ICACHE_BURST -- requirements
Module: icache_burst

Interface
REQ-001 SHALL provide parameter WAYS, default 2, associativity (power of two, 1..8).
REQ-002 SHALL provide parameter SETS, default 64, sets per way (power of two).
REQ-003 SHALL provide parameter LINE_WORDS, default 8, 32-bit words per line (power of two, 2..16).
REQ-004 SHALL provide parameter ADDR_WIDTH, default 32, fetch/AXI address width.
REQ-005 SHALL provide ports:
 ACLK  in  1  clock, rising edge; the block uses one clock; reset is synchronous and active-high.
 ARESET  in  1  synchronous active-high reset.
 CPU_REQ  in  1  fetch request.
 CPU_REQ_ADDR  in  ADDR_WIDTH  fetch address, word aligned.
 CPU_REQ_VALID  out  1  CPU_REQ_DATA valid this cycle.
 CPU_REQ_DATA  out  32  instruction; 0x00000013 (NOP) when not valid.
 BUSY  out  1  fetch stall.
 AR_VALID / AR_READY  out / in  1  read-address handshake.
 AR_ADDR  out  ADDR_WIDTH  line-aligned burst address.
 AR_LEN  out  8  beats minus one, constant LINE_WORDS-1.
 R_VALID / R_READY  in / out  1  read-data handshake.
 R_DATA  in  32  burst beat.
 R_LAST  in  1  final beat marker.
 FLUSH  in  1  invalidate-all request (present only with ICACHE_FLUSH_EN).

Function
REQ-006 Address split SHALL be TAG | INDEX (log2 SETS) | WORD (log2 LINE_WORDS) | 2'b00.
REQ-007 FSM states SHALL be IDLE, CMP, MREQ, REFILL, READ, plus INVAL with ICACHE_FLUSH_EN.
REQ-008 IDLE->CMP when CPU_REQ=1; CMP stays in CMP on hit with CPU_REQ=1, goes to IDLE on CPU_REQ=0, and goes to MREQ on miss with CPU_REQ=1.
REQ-009 In CMP, lookup SHALL be combinational on CPU_REQ_ADDR; on a hit, CPU_REQ_VALID=1 and data are driven in the same cycle (zero-wait hit).
REQ-010 On a miss, the block SHALL latch tag/index/word and the victim way, enter MREQ, and drive AR_VALID=1 with AR_ADDR line-aligned and AR_LEN=LINE_WORDS-1.
REQ-011 AR_VALID and AR_ADDR SHALL remain stable until AR_READY is sampled high; AR_VALID drops in the next cycle; the FSM then enters REFILL.
REQ-012 In REFILL, R_READY SHALL be 1; each R_VALID&R_READY beat writes beat counter slot `cnt` of the victim line, then increments `cnt`.
REQ-013 When the beat with cnt=LINE_WORDS-1 is accepted, the block SHALL set tag, set valid, update replacement state, and go to READ, regardless of R_LAST.
REQ-014 If R_LAST=1 on a beat with cnt<LINE_WORDS-1, the block SHALL abort: line left invalid, R_READY=0, FSM->CMP, which retries the fetch.
REQ-015 READ SHALL assert CPU_REQ_VALID=1 for one cycle with the latched word, then go to CMP if CPU_REQ=1, else to IDLE.
REQ-016 Once issued, a miss SHALL always complete even if CPU_REQ drops or CPU_REQ_ADDR changes; READ returns the latched-address word.
REQ-017 BUSY SHALL equal NOT CPU_REQ_VALID.
REQ-018 Victim selection: lowest-index invalid way first; if none is invalid, use a per-set round-robin pointer, which advances only on refill commit.
REQ-019 With WAYS=1, the victim SHALL always be way 0, and the pointer logic SHALL be absent.
REQ-020 Simultaneous hits in multiple ways SHALL NOT occur by construction; the lowest hit way wins.

Reset
REQ-021 ARESET=1 at a clock edge SHALL force: state IDLE, all valid bits 0, round-robin pointers 0, AR_VALID=0, R_READY=0, AR_ADDR=0, cnt=0.
REQ-022 Reset mid-burst SHALL abandon the transaction immediately; remaining R beats are not accepted because R_READY=0.
REQ-023 The data array SHALL NOT be reset.

Configuration
REQ-024 Macro ICACHE_FLUSH_EN defined: FLUSH=1 in IDLE/CMP/READ enters INVAL, clearing one set per cycle over SETS cycles with BUSY=1, then returns to IDLE.
REQ-025 FLUSH during MREQ/REFILL SHALL be remembered and take effect after READ.
REQ-026 Macro ICACHE_FLUSH_EN undefined: the FLUSH port and INVAL state SHALL NOT exist.

Verification
REQ-027 Cold fetch 0x100 -> AR_ADDR=0x100, AR_LEN=7; 8 beats 0xA0..0xA7 -> READ returns 0xA0; then fetch 0x11C -> same-cycle hit returns 0xA7.
REQ-028 Fetch 0x0, 0x800, 0x1000 with defaults (same index) -> third miss evicts way 0; re-fetch 0x0 misses.
REQ-029 AR_READY held low 5 cycles -> AR_VALID and AR_ADDR stable all 5 cycles; R_VALID gaps between beats -> still 8 writes, correct data.
REQ-030 R_LAST on beat 4 -> no valid set, refetch issued with the same AR_ADDR.
REQ-031 ARESET pulse during beat 3 -> IDLE, R_READY=0, previously valid hit at 0x104 now misses.
REQ-032 ICACHE_FLUSH_EN: FLUSH after warm hit -> BUSY for 64 cycles, then the same address misses.
